// File: rtl/mem_access_ctrl_if.sv
// Signal bundle between mem_access_ctrl and its two requesters plus the LC-3b memory.
// The controller takes the slave side; requesters and memory together form the master side.
interface mem_access_ctrl_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_done;
  logic [15:0] if_rdata;
  logic        if_err;

  logic        ls_req;
  logic        ls_we;
  logic        ls_byte;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_done;
  logic [15:0] ls_rdata;
  logic        ls_err;

  logic [15:0] mem_bus;
  logic        mem_ld_mar;
  logic        mem_ld_mdr;
  logic        mem_rw;
  logic        mem_datasize;
  logic        mem_r;
  logic [15:0] mem_mdr;

  logic        busy;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_byte, ls_addr, ls_wdata,
    input  mem_r, mem_mdr,
    output if_done, if_rdata, if_err,
    output ls_done, ls_rdata, ls_err,
    output mem_bus, mem_ld_mar, mem_ld_mdr, mem_rw, mem_datasize,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_byte, ls_addr, ls_wdata,
    output mem_r, mem_mdr,
    input  if_done, if_rdata, if_err,
    input  ls_done, ls_rdata, ls_err,
    input  mem_bus, mem_ld_mar, mem_ld_mdr, mem_rw, mem_datasize,
    input  busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Arbitrates fetch and load/store requests onto the LC-3b memory, sequencing MAR/MDR strobes,
// waiting for mem_r with a bounded timer, and reporting unaligned or timed-out accesses as errors.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 32
) (
  input logic              clk_50,
  input logic              reset,
  mem_access_ctrl_if.slave ctl
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAR,
    ST_MDR,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state_q,   state_d;
  logic        sel_ls_q,  sel_ls_d;
  logic        we_q,      we_d;
  logic        is_byte_q, is_byte_d;
  logic [15:0] addr_q,    addr_d;
  logic [15:0] wdata_q,   wdata_d;
  logic [15:0] rdata_q,   rdata_d;
  logic        err_q,     err_d;
  logic [7:0]  timer_q,   timer_d;
  logic        last_ls_q, last_ls_d;

  logic        grant_ls;
  logic        if_done, ls_done;
  logic [15:0] if_rdata, ls_rdata;
  logic        if_err, ls_err;
  logic [15:0] mem_bus;
  logic        mem_ld_mar, mem_ld_mdr, mem_rw, mem_datasize;

  // last_ls resets to 1 so that fetch wins the very first tie.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_ls_q  <= 1'b0;
      we_q      <= 1'b0;
      is_byte_q <= 1'b0;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      rdata_q   <= 16'h0000;
      err_q     <= 1'b0;
      timer_q   <= 8'h00;
      last_ls_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sel_ls_q  <= sel_ls_d;
      we_q      <= we_d;
      is_byte_q <= is_byte_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      last_ls_q <= last_ls_d;
    end
  end

  assign grant_ls = ctl.ls_req && (!ctl.if_req || !last_ls_q);

  always_comb begin
    state_d      = state_q;
    sel_ls_d     = sel_ls_q;
    we_d         = we_q;
    is_byte_d    = is_byte_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    timer_d      = timer_q;
    last_ls_d    = last_ls_q;
    if_done      = 1'b0;
    ls_done      = 1'b0;
    if_rdata     = 16'h0000;
    ls_rdata     = 16'h0000;
    if_err       = 1'b0;
    ls_err       = 1'b0;
    mem_bus      = 16'h0000;
    mem_ld_mar   = 1'b0;
    mem_ld_mdr   = 1'b0;
    mem_rw       = 1'b0;
    mem_datasize = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ctl.if_req || ctl.ls_req) begin
          sel_ls_d  = grant_ls;
          we_d      = grant_ls ? ctl.ls_we    : 1'b0;
          is_byte_d = grant_ls ? ctl.ls_byte  : 1'b0;
          addr_d    = grant_ls ? ctl.ls_addr  : ctl.if_addr;
          wdata_d   = grant_ls ? ctl.ls_wdata : 16'h0000;
          rdata_d   = 16'h0000;
          err_d     = 1'b0;
          timer_d   = 8'h00;
          // Odd word addresses never reach memory; they are answered straight from RESP.
          if (!is_byte_d && addr_d[0]) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_MAR;
          end
        end
      end

      ST_MAR: begin
        mem_bus      = addr_q;
        mem_ld_mar   = 1'b1;
        mem_rw       = we_q;
        mem_datasize = is_byte_q;
        state_d      = we_q ? ST_MDR : ST_WAIT;
      end

      ST_MDR: begin
        mem_bus      = is_byte_q ? {8'h00, wdata_q[7:0]} : wdata_q;
        mem_ld_mdr   = 1'b1;
        mem_rw       = we_q;
        mem_datasize = is_byte_q;
        state_d      = ST_WAIT;
      end

      ST_WAIT: begin
        mem_rw       = we_q;
        mem_datasize = is_byte_q;
        // A ready flag arriving on the expiry cycle still counts as success.
        if (ctl.mem_r) begin
          rdata_d = we_q ? 16'h0000 : ctl.mem_mdr;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timer_q == TIMEOUT_CNT) begin
          rdata_d = 16'h0000;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          timer_d = timer_q + 8'h01;
        end
      end

      ST_RESP: begin
        if_done   = !sel_ls_q;
        ls_done   = sel_ls_q;
        if_rdata  = sel_ls_q ? 16'h0000 : rdata_q;
        ls_rdata  = sel_ls_q ? rdata_q  : 16'h0000;
        if_err    = !sel_ls_q && err_q;
        ls_err    = sel_ls_q && err_q;
        last_ls_d = sel_ls_q;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign ctl.if_done      = if_done;
  assign ctl.if_rdata     = if_rdata;
  assign ctl.if_err       = if_err;
  assign ctl.ls_done      = ls_done;
  assign ctl.ls_rdata     = ls_rdata;
  assign ctl.ls_err       = ls_err;
  assign ctl.mem_bus      = mem_bus;
  assign ctl.mem_ld_mar   = mem_ld_mar;
  assign ctl.mem_ld_mdr   = mem_ld_mdr;
  assign ctl.mem_rw       = mem_rw;
  assign ctl.mem_datasize = mem_datasize;
  assign ctl.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a table of single transactions against a small memory
// model, plus hand-written sequences for reset, mid-transaction reset and arbitration ties.
module tb_mem_access_ctrl;

  logic clk_50 = 1'b0;
  logic reset;

  always #5 clk_50 = ~clk_50;

  mem_access_ctrl_if ifc ();

  mem_access_ctrl #(.TIMEOUT(8)) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .ctl    (ifc)
  );

  typedef struct {
    logic        is_ls;
    logic        we;
    logic        is_byte;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mdr;
    int          lat;
    int          exp_done;
    logic        exp_mar;
    logic [15:0] exp_mar_bus;
    logic        exp_mdr;
    logic [15:0] exp_mdr_bus;
    logic        exp_rw;
    logic        exp_ds;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  int passed = 0;
  int total  = 0;

  int          obs_done;
  logic        obs_ls;
  logic        obs_dual;
  logic [15:0] obs_rdata;
  logic        obs_err;
  int          obs_mar;
  logic [15:0] obs_mar_bus;
  int          obs_mdr;
  logic [15:0] obs_mdr_bus;
  logic        obs_ctrl_ok;
  logic        obs_bus_ok;
  logic        obs_busy_ok;
  logic        obs_idle_busy;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  // Runs one transaction; the memory raises mem_r for one cycle, lat cycles after the MAR strobe.
  task automatic applyStimulus(input vec_t v);
    int mar_cyc;
    mar_cyc       = -1;
    obs_done      = -1;
    obs_ls        = 1'b0;
    obs_dual      = 1'b0;
    obs_rdata     = 16'h0000;
    obs_err       = 1'b0;
    obs_mar       = 0;
    obs_mar_bus   = 16'h0000;
    obs_mdr       = 0;
    obs_mdr_bus   = 16'h0000;
    obs_ctrl_ok   = 1'b1;
    obs_bus_ok    = 1'b1;
    obs_busy_ok   = 1'b1;
    step();
    if (v.is_ls) begin
      ifc.ls_req   = 1'b1;
      ifc.ls_we    = v.we;
      ifc.ls_byte  = v.is_byte;
      ifc.ls_addr  = v.addr;
      ifc.ls_wdata = v.wdata;
    end else begin
      ifc.if_req  = 1'b1;
      ifc.if_addr = v.addr;
    end
    ifc.mem_mdr = v.mdr;
    for (int i = 1; i <= 60 && obs_done < 0; i++) begin
      step();
      if (ifc.mem_ld_mar) begin
        obs_mar++;
        obs_mar_bus = ifc.mem_bus;
        mar_cyc     = i;
      end
      if (ifc.mem_ld_mdr) begin
        obs_mdr++;
        obs_mdr_bus = ifc.mem_bus;
      end
      if (!ifc.mem_ld_mar && !ifc.mem_ld_mdr && ifc.mem_bus != 16'h0000) obs_bus_ok = 1'b0;
      if (!ifc.busy) obs_busy_ok = 1'b0;
      if (ifc.if_done || ifc.ls_done) begin
        obs_done  = i;
        obs_ls    = ifc.ls_done;
        obs_dual  = ifc.if_done && ifc.ls_done;
        obs_rdata = ifc.ls_done ? ifc.ls_rdata : ifc.if_rdata;
        obs_err   = ifc.ls_done ? ifc.ls_err   : ifc.if_err;
        if (ifc.mem_rw || ifc.mem_datasize) obs_ctrl_ok = 1'b0;
      end else if (ifc.mem_rw !== v.exp_rw || ifc.mem_datasize !== v.exp_ds) begin
        obs_ctrl_ok = 1'b0;
      end
      ifc.mem_r = (obs_done < 0) && (mar_cyc > 0) && (v.lat > 0) && (i == mar_cyc + v.lat);
    end
    ifc.if_req = 1'b0;
    ifc.ls_req = 1'b0;
    ifc.mem_r  = 1'b0;
    step();
    obs_idle_busy = ifc.busy;
  endtask

  task automatic checkRecord(input int k, input vec_t v);
    checkOutput($sformatf("r%0d done cycle", k), obs_done, v.exp_done);
    checkOutput($sformatf("r%0d done port", k), obs_ls, v.is_ls);
    checkOutput($sformatf("r%0d dual done", k), obs_dual, 0);
    checkOutput($sformatf("r%0d rdata", k), obs_rdata, v.exp_rdata);
    checkOutput($sformatf("r%0d err", k), obs_err, v.exp_err);
    checkOutput($sformatf("r%0d mar strobes", k), obs_mar, v.exp_mar ? 1 : 0);
    if (v.exp_mar) checkOutput($sformatf("r%0d mar bus", k), obs_mar_bus, v.exp_mar_bus);
    checkOutput($sformatf("r%0d mdr strobes", k), obs_mdr, v.exp_mdr ? 1 : 0);
    if (v.exp_mdr) checkOutput($sformatf("r%0d mdr bus", k), obs_mdr_bus, v.exp_mdr_bus);
    checkOutput($sformatf("r%0d rw/datasize", k), obs_ctrl_ok, 1);
    checkOutput($sformatf("r%0d bus quiet", k), obs_bus_ok, 1);
    checkOutput($sformatf("r%0d busy", k), obs_busy_ok, 1);
    checkOutput($sformatf("r%0d idle after", k), obs_idle_busy, 0);
  endtask

  // Both requesters raised together; memory answers on the first WAIT cycle each time.
  task automatic tieRun(input string tag, input int exp_first);
    int first;
    int n_done;
    first  = -1;
    n_done = 0;
    step();
    ifc.if_req   = 1'b1;
    ifc.if_addr  = 16'h3000;
    ifc.ls_req   = 1'b1;
    ifc.ls_we    = 1'b0;
    ifc.ls_byte  = 1'b0;
    ifc.ls_addr  = 16'h0200;
    ifc.ls_wdata = 16'h0000;
    ifc.mem_mdr  = 16'h00AA;
    for (int i = 1; i <= 80 && n_done < 2; i++) begin
      step();
      if (ifc.if_done) begin
        if (first < 0) first = 0;
        n_done++;
        ifc.if_req = 1'b0;
      end
      if (ifc.ls_done) begin
        if (first < 0) first = 1;
        n_done++;
        ifc.ls_req = 1'b0;
      end
      ifc.mem_r = ifc.busy && !ifc.mem_ld_mar && !ifc.mem_ld_mdr && !ifc.if_done && !ifc.ls_done;
    end
    ifc.if_req = 1'b0;
    ifc.ls_req = 1'b0;
    ifc.mem_r  = 1'b0;
    step();
    checkOutput({tag, " first grant"}, first, exp_first);
    checkOutput({tag, " both served"}, n_done, 2);
  endtask

  initial begin
    //            ls  we  byt addr      wdata     mdr      lat done mar mar_bus  mdr mdr_bus  rw  ds  rdata     err
    vecs[0]  = '{1'b0,1'b0,1'b0,16'h3000,16'h0000,16'h1234, 5,  7, 1'b1,16'h3000,1'b0,16'h0000,1'b0,1'b0,16'h1234,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,16'h0000,16'h0007,16'hBEEF, 3,  5, 1'b1,16'h0000,1'b1,16'h0007,1'b1,1'b0,16'h0000,1'b0};
    vecs[2]  = '{1'b1,1'b1,1'b1,16'h0011,16'hAB55,16'hBEEF, 2,  4, 1'b1,16'h0011,1'b1,16'h0055,1'b1,1'b1,16'h0000,1'b0};
    vecs[3]  = '{1'b1,1'b0,1'b1,16'h0011,16'h0000,16'h0055, 1,  3, 1'b1,16'h0011,1'b0,16'h0000,1'b0,1'b1,16'h0055,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b0,16'h0101,16'h0000,16'h1111, 1,  1, 1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b1};
    vecs[5]  = '{1'b1,1'b0,1'b1,16'h0101,16'h0000,16'hFF80, 1,  3, 1'b1,16'h0101,1'b0,16'h0000,1'b0,1'b1,16'hFF80,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b0,16'h0100,16'h0000,16'h8001, 3,  5, 1'b1,16'h0100,1'b0,16'h0000,1'b0,1'b0,16'h8001,1'b0};
    vecs[7]  = '{1'b1,1'b1,1'b0,16'h2000,16'h1111,16'h2222, 0, 12, 1'b1,16'h2000,1'b1,16'h1111,1'b1,1'b0,16'h0000,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,16'h4000,16'h0000,16'h7777, 0, 11, 1'b1,16'h4000,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b1};
    vecs[9]  = '{1'b0,1'b0,1'b0,16'h3001,16'h0000,16'h7777, 1,  1, 1'b0,16'h0000,1'b0,16'h0000,1'b0,1'b0,16'h0000,1'b1};
    vecs[10] = '{1'b0,1'b0,1'b0,16'h3002,16'h0000,16'h5A5A, 9, 11, 1'b1,16'h3002,1'b0,16'h0000,1'b0,1'b0,16'h5A5A,1'b0};

    reset        = 1'b1;
    ifc.if_req   = 1'b0;
    ifc.if_addr  = 16'h0000;
    ifc.ls_req   = 1'b0;
    ifc.ls_we    = 1'b0;
    ifc.ls_byte  = 1'b0;
    ifc.ls_addr  = 16'h0000;
    ifc.ls_wdata = 16'h0000;
    ifc.mem_r    = 1'b0;
    ifc.mem_mdr  = 16'h0000;
    step();
    step();
    checkOutput("reset busy", ifc.busy, 0);
    checkOutput("reset fetch outputs", {ifc.if_done, ifc.if_err, ifc.if_rdata}, 0);
    checkOutput("reset ls outputs", {ifc.ls_done, ifc.ls_err, ifc.ls_rdata}, 0);
    checkOutput("reset mem outputs",
                {ifc.mem_bus, ifc.mem_ld_mar, ifc.mem_ld_mdr, ifc.mem_rw, ifc.mem_datasize}, 0);
    reset = 1'b0;

    for (int k = 0; k < 11; k++) begin
      applyStimulus(vecs[k]);
      checkRecord(k, vecs[k]);
    end

    // Reset while waiting on memory: no done pulse, everything quiet on the next cycle.
    begin
      int dones;
      dones = 0;
      step();
      ifc.if_req  = 1'b1;
      ifc.if_addr = 16'h3000;
      step();
      step();
      step();
      checkOutput("pre-reset in wait", {ifc.busy, ifc.mem_ld_mar, ifc.mem_ld_mdr}, 3'b100);
      reset = 1'b1;
      step();
      checkOutput("abort busy", ifc.busy, 0);
      checkOutput("abort done", {ifc.if_done, ifc.ls_done, ifc.if_err, ifc.ls_err}, 0);
      checkOutput("abort mem outputs",
                  {ifc.mem_bus, ifc.mem_ld_mar, ifc.mem_ld_mdr, ifc.mem_rw, ifc.mem_datasize}, 0);
      reset      = 1'b0;
      ifc.if_req = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (ifc.if_done || ifc.ls_done) dones++;
      end
      checkOutput("abort no later done", dones, 0);
    end

    tieRun("tie after reset", 0);
    applyStimulus(vecs[0]);
    checkOutput("fetch before tie done cycle", obs_done, 7);
    tieRun("tie after fetch", 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller sitting directly upstream of the LC-3b `memory` block. It arbitrates between the instruction-fetch port and the load/store port, sequences the MAR/MDR load strobes, read/write and datasize controls toward memory, waits for the memory-ready flag, and returns read data or an error to the requester. Unaligned word accesses and memory timeouts are reported as errors rather than issued or hung on.

## Interface
Parameters:
- TIMEOUT, 32, max WAIT cycles without `mem_r` before error (1..255; 8-bit counter)

Ports:
- clk_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until `if_done`
- if_addr  in  16  fetch byte address (always a word read)
- if_done  out  1  one-cycle completion pulse to fetch
- if_rdata  out  16  fetch read data, valid with `if_done`
- if_err  out  1  error flag, valid with `if_done`
- ls_req  in  1  load/store request; held high until `ls_done`
- ls_we  in  1  1 = store, 0 = load
- ls_byte  in  1  1 = byte access, 0 = word
- ls_addr  in  16  load/store byte address
- ls_wdata  in  16  store data (byte store uses [7:0])
- ls_done  out  1  one-cycle completion pulse to load/store
- ls_rdata  out  16  load data, valid with `ls_done`
- ls_err  out  1  error flag, valid with `ls_done`
- mem_bus  out  16  address (MAR cycle) or write data (MDR cycle), else 0
- mem_ld_mar  out  1  one-cycle MAR load strobe
- mem_ld_mdr  out  1  one-cycle MDR load strobe
- mem_rw  out  1  1 = write; held for whole write transaction
- mem_datasize  out  1  1 = byte, 0 = word; held for whole transaction
- mem_r  in  1  memory ready
- mem_mdr  in  16  memory read data, valid when `mem_r` = 1
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, MAR, MDR, WAIT, RESP.
- IDLE: if any request, grant and latch requester id, we, byte, addr, wdata. Fetch latches we=0, byte=0.
- Arbitration: single request wins; both pending → grant the one NOT granted last. `last_grant` resets to load/store, so fetch wins the first tie.
- Alignment: word access with addr[0]=1 → skip memory, go IDLE→RESP with err=1, rdata=0. Byte access any address is legal.
- MAR: `mem_bus`=addr, `mem_ld_mar`=1. Write → MDR; read → WAIT.
- MDR: `mem_bus`=wdata (byte: {8'h00, wdata[7:0]}), `mem_ld_mdr`=1 → WAIT.
- WAIT: timer counts up from 0 each cycle. `mem_r`=1 → capture `mem_mdr` (reads) into rdata, err=0, → RESP. Timer reaches TIMEOUT with `mem_r`=0 → err=1, rdata=0, → RESP. `mem_r` in same cycle as expiry wins (success).
- RESP: assert granted requester's done with latched rdata/err for one cycle; update `last_grant`; → IDLE. Write success returns rdata=0.
- Byte read data passed through from `mem_mdr` unmodified (memory performs sign extension).
- `mem_rw`, `mem_datasize` driven from latched fields in MAR, MDR, WAIT; 0 in IDLE and RESP.
- Requests deasserted before done are a protocol violation; transaction still completes and pulses done.

## Timing
- Reset: state IDLE; all outputs 0 (`if_*`/`ls_*` outputs, `mem_*` outputs, `busy`); timer 0; `last_grant` = load/store.
- Reset mid-transaction: abort next edge, no done pulse, outputs 0.
- Read: request seen in IDLE at cycle N → MAR at N+1 → WAIT from N+2 → `mem_r` at cycle M → done at M+1.
- Write: MAR N+1, MDR N+2, WAIT from N+3, done one cycle after `mem_r`.
- Unaligned: done+err at N+1; no memory strobes.
- Timeout: done+err exactly TIMEOUT+1 cycles after WAIT entry.
- Back-to-back: IDLE after RESP; a held request is granted in that IDLE cycle (minimum 1 idle cycle between transactions).
- Ignore `mem_r` outside WAIT.

## Test plan
- Fetch read 0x3000, memory model asserts `mem_r` 5 cycles after MAR with 0x1234 → `mem_ld_mar` one cycle, bus=0x3000, `if_done` with rdata=0x1234, err=0.
- Store word 0x0007 to 0x0000 → MAR (bus 0x0000), MDR (bus 0x0007), `mem_rw`=1 throughout, `ls_done` err=0 one cycle after `mem_r`.
- Byte store 0xAB55 to 0x0011 → MDR bus=0x0055, datasize=1; byte load returns model's 0x0055 unchanged.
- Word load at 0x0101 → `ls_done`+`ls_err` next cycle, no `mem_ld_mar`.
- `mem_r` never asserted, TIMEOUT=8 → err done 9 cycles after WAIT entry, then IDLE.
- `if_req` and `ls_req` high together twice → fetch served first, load/store second; reset asserted in WAIT → no done, all outputs 0 next cycle.
